// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// state encoding and operand magnitude extraction.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The unused fourth code behaves exactly like IDLE.
    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE,
        RSVD = 2'd3
    } state_t;

    // Widest operand abs_w() can handle; callers zero-extend into it and truncate back.
    localparam int ABS_MAX_W = 64;

    // Two's-complement magnitude when is_neg is set. For the most-negative value,
    // the truncated result is exact as an unsigned number of the original width.
    function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] v,
                                                    input logic                 is_neg);
        return is_neg ? (~v + ABS_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_adder.sv
// N-bit ripple-carry adder built from full-adder cells; carry-out forms bit N of the sum.
module param_ripple_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[N];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock,
// signed/unsigned per operation, valid/ready handshakes on both sides.
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic               neg;
    logic [CNT_W-1:0]   counter;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum_lo;
    logic               sum_carry;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   acc_hi_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] result;
    logic [2*WIDTH-1:0] product_next;

    assign a_mag = WIDTH'(abs_w(ABS_MAX_W'(a), signed_mode & a[WIDTH-1]));
    assign b_mag = WIDTH'(abs_w(ABS_MAX_W'(b), signed_mode & b[WIDTH-1]));

    assign addend = mplier[0] ? mcand : '0;

    param_ripple_adder #(.N(WIDTH)) u_adder (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum_lo),
        .cout (sum_carry)
    );

    // The product shifts in from the top of acc_hi while consumed multiplier bits fall off mplier.
    assign sum_full     = {sum_carry, sum_lo};
    assign acc_hi_next  = sum_full[WIDTH:1];
    assign mplier_next  = {sum_full[0], mplier[WIDTH-1:1]};
    assign result       = {acc_hi_next, mplier_next};
    assign product_next = neg ? (~result + (2*WIDTH)'(1)) : result;

    // NOTE: every state element, datapath included, is async-reset so an aborted operation
    // leaves nothing behind; all updates are non-blocking so the shift reads pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
            zero      <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc_hi    <= '0;
            neg       <= 1'b0;
            counter   <= '0;
        end else begin
            case (state)
                RUN: begin
                    acc_hi  <= acc_hi_next;
                    mplier  <= mplier_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_ITER) begin
                        product   <= product_next;
                        zero      <= (result == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        zero      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                    if (in_valid && in_ready) begin
                        mcand    <= a_mag;
                        mplier   <= b_mag;
                        neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_hi   <= '0;
                        counter  <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: a 16-bit instance for the hand-computed
// vectors and a 4-bit instance swept over every operand pair in both modes.
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic        in_valid, in_ready, sm, out_valid, out_ready, zero;
    logic [15:0] a, b;
    logic [31:0] product;

    logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4, zero4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int checks = 0;
    int errors = 0;

    seq_shift_add_multiplier #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(sm), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .zero(zero)
    );

    seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4), .out_ready(out_ready4),
        .product(product4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: sign-interpret the 4-bit operands and multiply as integers.
    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic m);
        int xs = int'(x);
        int ys = int'(y);
        if (m && x[3]) xs = xs - 16;
        if (m && y[3]) ys = ys - 16;
        return 8'(xs * ys);
    endfunction

    task automatic wait_ready16(input string tag);
        int k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    // Issue one op on the 16-bit instance and check latency, product and zero flag.
    task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic smv,
                           input logic [31:0] exp, input string tag);
        int k = 0;
        wait_ready16(tag);
        a = av; b = bv; sm = smv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; sm = ~smv;
        check({tag, "_busy"}, 64'(in_ready), 64'(0));
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'(16));
        check({tag, "_prod"}, 64'(product), 64'(exp));
        check({tag, "_zero"}, 64'(zero), 64'(exp == 32'd0));
    endtask

    task automatic finish16(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'(0));
        check({tag, "_idle"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        int k;
        logic [7:0] exp4;

        reset = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sm = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 64'(in_ready), 64'(1));

        // Unsigned maximum.
        start16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_ffff");
        finish16("u_ffff");

        // Signed most-negative operands.
        start16(16'h8000, 16'hFFFF, 1'b1, 32'h00008000, "s_min_m1");
        finish16("s_min_m1");
        start16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_min");
        finish16("s_min_min");

        // Zero result under backpressure.
        start16(16'h0000, 16'h1234, 1'b0, 32'h0, "zero_bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_prod", 64'(product), 64'(0));
            check("bp_zero", 64'(zero), 64'(1));
            check("bp_in_ready", 64'(in_ready), 64'(0));
        end
        finish16("zero_bp");

        // Same operands, both modes.
        start16(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "s_m3x7");
        finish16("s_m3x7");
        start16(16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, "u_m3x7");
        finish16("u_m3x7");

        // Reset during iteration 7; the previous nonzero product must clear at once.
        wait_ready16("rst_run");
        a = 16'h00FF; b = 16'h0101; sm = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_product", 64'(product), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        check("midrst_held_valid", 64'(out_valid), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        start16(16'd3, 16'd5, 1'b0, 32'd15, "post_rst");
        finish16("post_rst");

        // 4-bit sweep with in_valid held high and random consumer stalls.
        in_valid4 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    a4 = 4'(x); b4 = 4'(y); sm4 = 1'(m);
                    exp4 = ref4(4'(x), 4'(y), 1'(m));
                    k = 0;
                    while (!in_ready4 && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    check("w4_ready", 64'(in_ready4), 64'(1));
                    @(negedge clk);
                    k = 0;
                    while (!out_valid4 && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    check("w4_lat", 64'(k), 64'(4));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    check("w4_prod", 64'(product4), 64'(exp4));
                    check("w4_zero", 64'(zero4), 64'(exp4 == 8'd0));
                    out_ready4 = 1'b1;
                    @(negedge clk);
                    out_ready4 = 1'b0;
                end
            end
        end
        in_valid4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
